// File: rtl/enc_bind_ctrl.sv
// -----------------------------------------------------------------------------
// enc_bind_ctrl
// Sequencer for the sparse-HDC encoder datapath. For each sample it clears the
// bundling accumulator, then for every feature: accepts one feature value,
// quantizes it to a level index, reads the level item memory, waits out the
// memory latency, pulses the binder and then the accumulator. After the last
// feature the finished sample HV is offered downstream until consumed.
//
// Ports
//   clk, nrst       clock, asynchronous active-low reset
//   en_i            global enable; low freezes the FSM and silences all strobes
//   abort_i         synchronous abort of the sample in progress
//   start_valid_i   request to encode a new sample
//   start_ready_o   controller idle and enabled, start is accepted
//   feat_valid_i    feature value available
//   feat_data_i     feature value
//   feat_ready_o    controller is waiting for a feature (a handshake consumes it)
//   mem_rd_en_o     item-memory read strobe
//   mem_addr_o      item-memory level address (top LVL_W bits of the feature)
//   bind_start_o    binder start pulse
//   acc_clear_o     accumulator clear pulse
//   acc_en_o        accumulator add pulse
//   acc_last_o      qualifies acc_en_o for the final feature of the sample
//   feat_idx_o      index of the feature in flight
//   hv_valid_o      sample HV complete in the accumulator
//   hv_ready_i      downstream consumed the sample HV
//   busy_o          controller is not idle
// -----------------------------------------------------------------------------
module enc_bind_ctrl #(
   parameter int NUM_FEATURES = 617,
   parameter int VAL_W        = 8,
   parameter int LVL_W        = 5,
   parameter int MEM_LAT      = 1,
   parameter int FIDX_W       = $clog2(NUM_FEATURES + 1)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              en_i,
   input  logic              abort_i,
   input  logic              start_valid_i,
   output logic              start_ready_o,
   input  logic              feat_valid_i,
   input  logic [VAL_W-1:0]  feat_data_i,
   output logic              feat_ready_o,
   output logic              mem_rd_en_o,
   output logic [LVL_W-1:0]  mem_addr_o,
   output logic              bind_start_o,
   output logic              acc_clear_o,
   output logic              acc_en_o,
   output logic              acc_last_o,
   output logic [FIDX_W-1:0] feat_idx_o,
   output logic              hv_valid_o,
   input  logic              hv_ready_i,
   output logic              busy_o
);

   // Latency counter only has to reach MEM_LAT-1.
   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(MEM_LAT - 1);
   localparam logic [LAT_W-1:0]  LAT_ZERO = LAT_W'(0);
   localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);
   localparam logic [FIDX_W-1:0] IDX_LAST = FIDX_W'(NUM_FEATURES - 1);
   localparam logic [FIDX_W-1:0] IDX_ZERO = FIDX_W'(0);
   localparam logic [FIDX_W-1:0] IDX_ONE  = FIDX_W'(1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CLEAR    = 3'd1,
      S_FETCH    = 3'd2,
      S_WAIT_MEM = 3'd3,
      S_BIND     = 3'd4,
      S_ACCUM    = 3'd5,
      S_DONE     = 3'd6
   } state_e;

   state_e            state_q, state_d;
   logic [FIDX_W-1:0] idx_q, idx_d;
   logic [LAT_W-1:0]  lat_q, lat_d;

   logic              go_s;
   logic              last_s;
   logic              start_ready_s;
   logic              feat_ready_s;
   logic              mem_rd_en_s;
   logic [LVL_W-1:0]  mem_addr_s;
   logic              bind_start_s;
   logic              acc_clear_s;
   logic              acc_en_s;
   logic              acc_last_s;
   logic              hv_valid_s;

   // Only the top LVL_W bits select a level; the low bits are intentionally dropped.
   logic              unused_s;
   assign unused_s = ^feat_data_i;

   // Strobes fire only when enabled and not being aborted in the same cycle,
   // so an aborted sample never adds a further feature or flags a last one.
   assign go_s   = en_i & ~abort_i;
   assign last_s = (idx_q == IDX_LAST);

   // State, feature index and latency counter registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_IDLE;
         idx_q   <= IDX_ZERO;
         lat_q   <= LAT_ZERO;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         lat_q   <= lat_d;
      end
   end

   // Next-state and output decode; abort overrides everything at the end.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      lat_d         = lat_q;
      start_ready_s = 1'b0;
      feat_ready_s  = 1'b0;
      mem_rd_en_s   = 1'b0;
      mem_addr_s    = {LVL_W{1'b0}};
      bind_start_s  = 1'b0;
      acc_clear_s   = 1'b0;
      acc_en_s      = 1'b0;
      acc_last_s    = 1'b0;
      hv_valid_s    = 1'b0;

      case (state_q)
         S_IDLE: begin
            start_ready_s = en_i;
            if (en_i && start_valid_i) begin
               state_d = S_CLEAR;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_CLEAR: begin
            acc_clear_s = go_s;
            if (en_i) begin
               idx_d   = IDX_ZERO;
               state_d = S_FETCH;
            end else begin
               state_d = S_CLEAR;
            end
         end

         S_FETCH: begin
            // Address is a straight slice of the feature so the read issues in
            // the same cycle the feature is consumed.
            feat_ready_s = en_i;
            mem_addr_s   = feat_data_i[VAL_W-1 -: LVL_W];
            mem_rd_en_s  = feat_valid_i & go_s;
            if (feat_valid_i && en_i) begin
               lat_d   = LAT_ZERO;
               state_d = S_WAIT_MEM;
            end else begin
               state_d = S_FETCH;
            end
         end

         S_WAIT_MEM: begin
            // Item memory keeps its read data until the next read strobe, so
            // leaving after exactly MEM_LAT cycles is safe.
            if (en_i) begin
               if (lat_q == LAT_LAST) begin
                  state_d = S_BIND;
               end else begin
                  lat_d = lat_q + LAT_ONE;
               end
            end else begin
               state_d = S_WAIT_MEM;
            end
         end

         S_BIND: begin
            bind_start_s = go_s;
            if (en_i) begin
               state_d = S_ACCUM;
            end else begin
               state_d = S_BIND;
            end
         end

         S_ACCUM: begin
            // Binder output is registered, so it is valid in this cycle.
            acc_en_s   = go_s;
            acc_last_s = go_s & last_s;
            if (en_i) begin
               if (last_s) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + IDX_ONE;
                  state_d = S_FETCH;
               end
            end else begin
               state_d = S_ACCUM;
            end
         end

         S_DONE: begin
            // hv_valid is held through an enable stall; only an enabled
            // handshake releases it.
            hv_valid_s = 1'b1;
            if (en_i && hv_ready_i) begin
               idx_d   = IDX_ZERO;
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end

         default: begin
            idx_d   = IDX_ZERO;
            lat_d   = LAT_ZERO;
            state_d = S_IDLE;
         end
      endcase

      // Abort wins even with en low; in IDLE there is nothing to abort.
      if (abort_i && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         idx_d   = IDX_ZERO;
         lat_d   = LAT_ZERO;
      end else begin
         state_d = state_d;
      end
   end

   assign start_ready_o = start_ready_s;
   assign feat_ready_o  = feat_ready_s;
   assign mem_rd_en_o   = mem_rd_en_s;
   assign mem_addr_o    = mem_addr_s;
   assign bind_start_o  = bind_start_s;
   assign acc_clear_o   = acc_clear_s;
   assign acc_en_o      = acc_en_s;
   assign acc_last_o    = acc_last_s;
   assign feat_idx_o    = idx_q;
   assign hv_valid_o    = hv_valid_s;
   assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_enc_bind_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for enc_bind_ctrl. Two instances: dut0 with MEM_LAT=1 and dut1 with
// MEM_LAT=3, both NUM_FEATURES=4. Stimulus pushes expected accumulator events
// and HV-ready times into per-instance queues; a negedge monitor pops and
// compares whenever an instance presents acc_en or a rising hv_valid.
// Times are counted relative to the acc_clear cycle of the sample.
// -----------------------------------------------------------------------------
module tb_enc_bind_ctrl;

   localparam int NF = 4;
   localparam int FW = $clog2(NF + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       nrst, en, abort, sv0, sv1, feat_valid, hv_ready;
   logic [7:0] feat_data;

   logic          sr0, fr0, mre0, bs0, ac0, ae0, al0, hv0, busy0;
   logic [4:0]    ma0;
   logic [FW-1:0] fi0;
   logic          sr1, fr1, mre1, bs1, ac1, ae1, al1, hv1, busy1;
   logic [4:0]    ma1;
   logic [FW-1:0] fi1;

   enc_bind_ctrl #(.NUM_FEATURES(NF), .VAL_W(8), .LVL_W(5), .MEM_LAT(1)) dut0 (
      .clk(clk), .nrst(nrst), .en_i(en), .abort_i(abort),
      .start_valid_i(sv0), .start_ready_o(sr0),
      .feat_valid_i(feat_valid), .feat_data_i(feat_data), .feat_ready_o(fr0),
      .mem_rd_en_o(mre0), .mem_addr_o(ma0), .bind_start_o(bs0),
      .acc_clear_o(ac0), .acc_en_o(ae0), .acc_last_o(al0), .feat_idx_o(fi0),
      .hv_valid_o(hv0), .hv_ready_i(hv_ready), .busy_o(busy0));

   enc_bind_ctrl #(.NUM_FEATURES(NF), .VAL_W(8), .LVL_W(5), .MEM_LAT(3)) dut1 (
      .clk(clk), .nrst(nrst), .en_i(en), .abort_i(abort),
      .start_valid_i(sv1), .start_ready_o(sr1),
      .feat_valid_i(feat_valid), .feat_data_i(feat_data), .feat_ready_o(fr1),
      .mem_rd_en_o(mre1), .mem_addr_o(ma1), .bind_start_o(bs1),
      .acc_clear_o(ac1), .acc_en_o(ae1), .acc_last_o(al1), .feat_idx_o(fi1),
      .hv_valid_o(hv1), .hv_ready_i(hv_ready), .busy_o(busy1));

   typedef struct { int rel; int idx; int last; int addr; } acc_exp_t;
   typedef struct { logic [7:0] val; int gap; } feat_t;

   acc_exp_t qa0[$];
   acc_exp_t qa1[$];
   int       qh0[$];
   int       qh1[$];
   feat_t    fq[$];

   int n_chk  = 0;
   int n_fail = 0;
   int rel_m[2];
   int addr_m[2];
   bit hvp[2];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Feature source: presents the queue head; a gap holds valid low for that
   // many cycles in which the controller is ready.
   initial begin
      feat_valid = 1'b0;
      feat_data  = 8'h00;
      forever begin
         bit    hs, rdy;
         feat_t h;
         @(negedge clk);
         rdy = fr0 | fr1;
         hs  = feat_valid & rdy;
         @(posedge clk);
         #1;
         if (fq.size() > 0) begin
            if (hs) begin
               void'(fq.pop_front());
            end else if (rdy && fq[0].gap > 0) begin
               h = fq[0];
               h.gap = h.gap - 1;
               fq[0] = h;
            end
         end
         if (fq.size() > 0 && fq[0].gap == 0) begin
            feat_valid = 1'b1;
            feat_data  = fq[0].val;
         end else begin
            feat_valid = 1'b0;
            feat_data  = 8'h00;
         end
      end
   end

   task automatic mon(input int d, input logic ac, input logic mre, input int ma,
                      input logic bs, input logic ae, input logic al, input int fi,
                      input logic hv);
      acc_exp_t e;
      int       npend;
      rel_m[d]++;
      if (ac) rel_m[d] = 0;
      chk($sformatf("pulse_exclusive%0d", d), int'(ac) + int'(mre) + int'(bs) + int'(ae), int'(ac | mre | bs | ae));
      if (!en) chk($sformatf("en_low_pulse%0d", d), int'(ac | mre | bs | ae), 0);
      chk($sformatf("acc_last_alone%0d", d), int'(al & ~ae), 0);
      if (mre) addr_m[d] = ma;
      if (ae) begin
         npend = (d == 0) ? qa0.size() : qa1.size();
         chk($sformatf("acc_en_expected%0d", d), int'(npend > 0), 1);
         if (npend > 0) begin
            e = (d == 0) ? qa0.pop_front() : qa1.pop_front();
            chk($sformatf("acc_en_time%0d", d), rel_m[d], e.rel);
            chk($sformatf("feat_idx%0d", d), fi, e.idx);
            chk($sformatf("acc_last%0d", d), int'(al), e.last);
            chk($sformatf("mem_addr%0d", d), addr_m[d], e.addr);
         end
      end
      if (hv && !hvp[d]) begin
         npend = (d == 0) ? qh0.size() : qh1.size();
         chk($sformatf("hv_expected%0d", d), int'(npend > 0), 1);
         if (npend > 0) begin
            chk($sformatf("hv_time%0d", d), rel_m[d], (d == 0) ? qh0.pop_front() : qh1.pop_front());
         end
      end
      hvp[d] = hv;
   endtask

   // Output monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (!nrst) begin
         hvp[0] = 1'b0;
         hvp[1] = 1'b0;
      end else begin
         mon(0, ac0, mre0, int'(ma0), bs0, ae0, al0, int'(fi0), hv0);
         mon(1, ac1, mre1, int'(ma1), bs1, ae1, al1, int'(fi1), hv1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Loads the features and pushes expectations. Features from index sk on
   // are delayed by sn cycles; use_gap makes that delay a source gap.
   task automatic plan(input int d, input int lat, input logic [31:0] vals,
                       input int sk, input int sn, input bit use_gap,
                       input int nexp, input bit with_hv);
      acc_exp_t e;
      feat_t    f;
      logic [7:0] v;
      for (int k = 0; k < NF; k++) begin
         v     = vals[31 - 8*k -: 8];
         f.val = v;
         f.gap = (use_gap && k == sk) ? sn : 0;
         fq.push_back(f);
         if (k < nexp) begin
            e.rel  = (3 + lat) * (k + 1) + ((k >= sk) ? sn : 0);
            e.idx  = k;
            e.last = (k == NF - 1) ? 1 : 0;
            e.addr = int'(v[7:3]);
            if (d == 0) qa0.push_back(e); else qa1.push_back(e);
         end
      end
      if (with_hv) begin
         if (d == 0) qh0.push_back(1 + NF * (3 + lat) + sn);
         else        qh1.push_back(1 + NF * (3 + lat) + sn);
      end
   endtask

   task automatic start(input int d);
      if (d == 0) sv0 = 1'b1; else sv1 = 1'b1;
      tick();
      sv0 = 1'b0;
      sv1 = 1'b0;
   endtask

   // Waits (bounded) for hv_valid; c counts cycles since start accept.
   task automatic wait_hv(input int d, input int c0, output int c);
      c = c0;
      while (((d == 0) ? hv0 : hv1) == 1'b0 && c < 300) begin
         tick();
         c++;
      end
      chk($sformatf("hv_reached%0d", d), int'((d == 0) ? hv0 : hv1), 1);
   endtask

   task automatic hv_accept();
      hv_ready = 1'b1;
      tick();
      hv_ready = 1'b0;
   endtask

   // Run-time bound.
   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      nrst = 1'b0; en = 1'b1; abort = 1'b0; sv0 = 1'b0; sv1 = 1'b0; hv_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_busy", int'(busy0), 0);
      chk("rst_start_ready", int'(sr0), 1);
      chk("rst_hv_valid", int'(hv0), 0);
      chk("rst_feat_idx", int'(fi0), 0);
      chk("rst_strobes", int'({ac0, ae0, bs0, mre0, fr0, al0}), 0);
      nrst = 1'b1;
      tick();

      // 1) basic sample
      plan(0, 1, 32'h10203040, NF, 0, 1'b0, NF, 1'b1);
      start(0);
      chk("t1_acc_clear", int'(ac0), 1);
      chk("t1_busy", int'(busy0), 1);
      chk("t1_start_ready", int'(sr0), 0);
      wait_hv(0, 1, c);
      chk("t1_hv_cycle", c, 18);
      hv_accept();
      chk("t1_idle", int'(busy0), 0);
      chk("t1_idx_cleared", int'(fi0), 0);

      // 2) quantization boundaries, stray start mid-sample
      plan(0, 1, 32'hF807803F, NF, 0, 1'b0, NF, 1'b1);
      start(0);
      tick(); tick();
      sv0 = 1'b1;
      tick();
      sv0 = 1'b0;
      wait_hv(0, 4, c);
      chk("t2_hv_cycle", c, 18);
      hv_accept();
      tick();
      chk("t2_start_not_queued", int'(busy0), 0);

      // 3) five-cycle feature gap before feature 2
      plan(0, 1, 32'h11223344, 2, 5, 1'b1, NF, 1'b1);
      start(0);
      wait_hv(0, 1, c);
      chk("t3_hv_cycle", c, 23);
      hv_accept();

      // 4) enable stall in WAIT_MEM of feature 1, then in DONE
      plan(0, 1, 32'h55667788, 1, 3, 1'b0, NF, 1'b1);
      start(0);
      repeat (6) tick();
      en = 1'b0;
      repeat (3) tick();
      en = 1'b1;
      wait_hv(0, 10, c);
      chk("t4_hv_cycle", c, 21);
      en = 1'b0;
      hv_ready = 1'b1;
      repeat (3) begin
         tick();
         chk("t4_hv_held", int'(hv0), 1);
         chk("t4_busy_held", int'(busy0), 1);
      end
      en = 1'b1;
      tick();
      hv_ready = 1'b0;
      chk("t4_idle", int'(busy0), 0);

      // 5) abort during BIND of feature 1
      plan(0, 1, 32'h99AABBCC, NF, 0, 1'b0, 1, 1'b0);
      start(0);
      repeat (7) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      fq.delete();
      chk("t5_idle", int'(busy0), 0);
      chk("t5_start_ready", int'(sr0), 1);
      chk("t5_feat_idx", int'(fi0), 0);
      chk("t5_no_hv", int'(hv0), 0);
      repeat (3) tick();
      plan(0, 1, 32'hA0B0C0D0, NF, 0, 1'b0, NF, 1'b1);
      start(0);
      chk("t5_restart_clear", int'(ac0), 1);
      chk("t5_restart_idx", int'(fi0), 0);
      wait_hv(0, 1, c);
      chk("t5_hv_cycle", c, 18);
      hv_accept();

      // 6) reset in ACCUM of feature 0, then a MEM_LAT=3 sample
      plan(0, 1, 32'h01020304, NF, 0, 1'b0, 0, 1'b0);
      start(0);
      repeat (4) tick();
      nrst = 1'b0;
      #1;
      chk("t6_rst_busy", int'(busy0), 0);
      chk("t6_rst_start_ready", int'(sr0), 1);
      chk("t6_rst_acc_en", int'(ae0), 0);
      chk("t6_rst_idx", int'(fi0), 0);
      chk("t6_rst_hv", int'(hv0), 0);
      fq.delete();
      tick(); tick();
      nrst = 1'b1;
      tick();
      chk("t6_lat3_idle", int'(busy1), 0);
      plan(1, 3, 32'h08F01FE0, NF, 0, 1'b0, NF, 1'b1);
      start(1);
      chk("t6_lat3_clear", int'(ac1), 1);
      wait_hv(1, 1, c);
      chk("t6_lat3_hv_cycle", c, 26);
      hv_accept();
      chk("t6_lat3_done", int'(busy1), 0);

      tick(); tick();
      chk("drained_acc0", qa0.size(), 0);
      chk("drained_acc1", qa1.size(), 0);
      chk("drained_hv0", qh0.size(), 0);
      chk("drained_hv1", qh1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
